// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data extraction, stall-safe read-data holding
// and a retirement counter.
module mem_wb_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ValidIn,
    input  logic [31:0] AluResult,
    input  logic [2:0]  LoadType,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] MemReadData,
    input  logic        Stall,
    input  logic        Flush,
    output logic [31:0] WbData,
    output logic [4:0]  WbReg,
    output logic        WbRegWrite,
    output logic        WbValid,
    output logic [15:0] RetireCount
);

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_H    = 3'd2,
        LD_HU   = 3'd3,
        LD_B    = 3'd4,
        LD_BU   = 3'd5
    } load_e;

    logic        valid_q;
    logic [31:0] alu_q;
    logic [2:0]  load_q;
    logic        reg_write_q;
    logic [4:0]  write_reg_q;
    logic [31:0] hold_q;
    logic        hold_valid_q;
    logic [15:0] retire_q;

    // Pipeline register: Stall wins over Flush; Flush only kills the valid bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q     <= 1'b0;
            alu_q       <= 32'd0;
            load_q      <= 3'd0;
            reg_write_q <= 1'b0;
            write_reg_q <= 5'd0;
        end else if (!Stall) begin
            valid_q     <= ValidIn & ~Flush;
            alu_q       <= AluResult;
            load_q      <= LoadType;
            reg_write_q <= RegWrite;
            write_reg_q <= WriteReg;
        end
    end

    // The memory output is only valid for one cycle after the address; keep it
    // across a stall so the held load still sees its own data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q       <= 32'd0;
            hold_valid_q <= 1'b0;
        end else if (!Stall) begin
            hold_valid_q <= 1'b0;
        end else if (!hold_valid_q) begin
            hold_q       <= MemReadData;
            hold_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retire_q <= 16'd0;
        end else if (!Stall && valid_q) begin
            retire_q <= retire_q + 16'd1;
        end
    end

    logic [31:0] read_src;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] wb_data;

    always_comb begin
        read_src = hold_valid_q ? hold_q : MemReadData;
        half_sel = alu_q[1] ? read_src[31:16] : read_src[15:0];
        byte_sel = read_src[7:0];
        case (alu_q[1:0])
            2'd0:    byte_sel = read_src[7:0];
            2'd1:    byte_sel = read_src[15:8];
            2'd2:    byte_sel = read_src[23:16];
            default: byte_sel = read_src[31:24];
        endcase

        // Encodings 6 and 7 fall into the default and behave as non-loads.
        wb_data = alu_q;
        case (load_q)
            LD_W:    wb_data = read_src;
            LD_H:    wb_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   wb_data = {16'd0, half_sel};
            LD_B:    wb_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   wb_data = {24'd0, byte_sel};
            default: wb_data = alu_q;
        endcase
    end

    assign WbData      = wb_data;
    assign WbReg       = write_reg_q;
    assign WbRegWrite  = valid_q & reg_write_q & (write_reg_q != 5'd0);
    assign WbValid     = valid_q;
    assign RetireCount = retire_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RST  input  1  asynchronous, active-high reset.
REQ-003 ValidIn  input  1  instruction in MEM stage this cycle is real (not bubble).
REQ-004 AluResult  input  32  MEM-stage ALU result / byte address, same value driven to data memory.
REQ-005 LoadType  input  3  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU; 6-7 treated as 0.
REQ-006 RegWrite  input  1  MEM-stage instruction writes register file.
REQ-007 WriteReg  input  5  MEM-stage destination register.
REQ-008 MemReadData  input  32  data memory output; valid the cycle after AluResult was presented (synchronous read).
REQ-009 Stall  input  1  hold WB stage contents.
REQ-010 Flush  input  1  replace incoming MEM instruction with bubble.
REQ-011 WbData  output  32  value to write to register file.
REQ-012 WbReg  output  5  destination register.
REQ-013 WbRegWrite  output  1  register-file write enable (already qualified by valid).
REQ-014 WbValid  output  1  WB stage holds a real instruction.
REQ-015 RetireCount  output  16  count of retired valid instructions, wraps.

Function
REQ-016 Pipeline register captures ValidIn, AluResult, LoadType, RegWrite, WriteReg on each edge where Stall=0.
REQ-017 Flush=1 with Stall=0: captured valid bit SHALL be 0; other fields don't-care.
REQ-018 Stall=1 overrides Flush; register contents unchanged.
REQ-019 Read-data source: hold register if HoldValid=1, else live MemReadData.
REQ-020 First Stall cycle (Stall=1, HoldValid=0): capture MemReadData into hold register, set HoldValid=1 on that edge.
REQ-021 HoldValid SHALL clear on first edge with Stall=0; hold register unchanged while HoldValid=1.
REQ-022 Extraction uses registered address bits A[1:0] and registered LoadType.
REQ-023 LW: data = source[31:0]; A[1:0] ignored.
REQ-024 LH/LHU: A[1]=0 selects source[15:0], A[1]=1 selects source[31:16]; LH sign-extends bit 15 of selected half, LHU zero-extends; A[0] ignored.
REQ-025 LB/LBU: A[1:0]=n selects source[8n+7:8n]; LB sign-extends bit 7, LBU zero-extends.
REQ-026 LoadType none: WbData = registered AluResult.
REQ-027 WbData, WbReg combinational from registered fields and read source; no added latency beyond the pipeline register.
REQ-028 WbRegWrite = registered valid AND registered RegWrite AND (registered WriteReg != 0).
REQ-029 WbValid = registered valid.
REQ-030 RetireCount increments by 1 on each edge with Stall=0 and WbValid=1; 16'hFFFF wraps to 0.

Reset
REQ-031 RST=1 asynchronously clears valid, RegWrite, LoadType, WriteReg, AluResult, hold register, HoldValid, RetireCount to 0.
REQ-032 During/after reset until first capture: WbValid=0, WbRegWrite=0, WbReg=0, WbData=0, RetireCount=0.
REQ-033 Reset asserted mid-stall discards held data; HoldValid=0 after release.

Verification
REQ-034 LW: AluResult=0x100, LoadType=1, WriteReg=8, RegWrite=1, ValidIn=1; next cycle MemReadData=0x8765_4321 -> WbData=0x87654321, WbReg=8, WbRegWrite=1.
REQ-035 Halves/bytes with MemReadData=0x80F1_7F02: LH A=2 -> 0xFFFF80F1; LHU A=2 -> 0x000080F1; LH A=0 -> 0x00007F02; LB A=3 -> 0xFFFFFF80; LBU A=1 -> 0x0000007F; LB A=0 -> 0x00000002.
REQ-036 Stall: load captured, Stall=1 for 3 cycles while MemReadData changes 0x11111111 -> 0x22222222 -> 0x33333333 -> WbData stays first-cycle value 0x11111111; RetireCount unchanged; after release next instruction captured.
REQ-037 Flush=1 with Stall=0 and ValidIn=1 -> next cycle WbValid=0, WbRegWrite=0; Flush=1 with Stall=1 -> contents held.
REQ-038 WriteReg=0, RegWrite=1, non-load AluResult=0x1234 -> WbData=0x1234, WbRegWrite=0, WbValid=1.
REQ-039 RST pulsed mid-stream, between edges -> all outputs 0 immediately; RetireCount from 0xFFFF plus one retirement -> 0x0000.
